// File: rtl/io_supply_seq.sv
// io_supply_seq: supply-good synchronizer/debouncer and pad-ring IO domain power sequencer
// Domains come up one per step, isolation releases last; losing the supply mid-sequence latches a fault.
module io_supply_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16,
  parameter int STEP_W      = 8,
  parameter int N_DOM       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsup_ok_i,
  input  logic              enable_i,
  input  logic [STEP_W-1:0] step_dly_i,
  input  logic              fault_clr_i,
  output logic [N_DOM-1:0]  dom_en_o,
  output logic              iso_o,
  output logic              ready_o,
  output logic              fault_o
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, DEBOUNCE, RAMP_UP, ISO_REL, UP, RAMP_DN} state_t;
  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0]          deb_q;
  logic [STEP_W-1:0]      step_q;
  logic [N_DOM-1:0]       dom_q;
  logic                   iso_q;
  logic                   ready_q;
  logic                   fault_q;
  logic                   vsup_s;
  logic                   step_done;
  logic                   brown;
  logic [N_DOM-1:0]       dom_up;
  logic [N_DOM-1:0]       dom_dn;
  assign vsup_s    = sync_q[SYNC_STAGES-1];
  assign step_done = step_q == '0;
  assign brown     = !vsup_s && (state_q inside {RAMP_UP, ISO_REL, UP, RAMP_DN});
  assign dom_up    = (dom_q << 1) | N_DOM'(1);
  assign dom_dn    = dom_q >> 1;
  assign dom_en_o  = dom_q;
  assign iso_o     = iso_q;
  assign ready_o   = ready_q;
  assign fault_o   = fault_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], vsup_ok_i};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      deb_q   <= '0;
      step_q  <= '0;
      dom_q   <= '0;
      iso_q   <= 1'b1;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (brown) begin
      // supply loss beats any enable change or step completion in the same cycle
      state_q <= IDLE;
      step_q  <= '0;
      dom_q   <= '0;
      iso_q   <= 1'b1;
      ready_q <= 1'b0;
      fault_q <= 1'b1;
    end else begin
      if (fault_clr_i) fault_q <= 1'b0;
      case (state_q)
        IDLE: if (enable_i && vsup_s && !fault_q) state_q <= DEBOUNCE;
        DEBOUNCE:
          if (!vsup_s || !enable_i) begin
            deb_q   <= '0;
            state_q <= IDLE;
          end else if (deb_q == DW'(DEB_CYCLES)) begin
            deb_q   <= '0;
            dom_q   <= N_DOM'(1);
            step_q  <= step_dly_i;
            state_q <= (N_DOM == 1) ? ISO_REL : RAMP_UP;
          end else deb_q <= deb_q + 1'b1;
        RAMP_UP, ISO_REL, UP:
          if (!enable_i) begin
            iso_q   <= 1'b1;
            ready_q <= 1'b0;
            step_q  <= step_dly_i;
            state_q <= (dom_q == '0) ? IDLE : RAMP_DN;
          end else if (!step_done) step_q <= step_q - 1'b1;
          else if (state_q == RAMP_UP) begin
            dom_q  <= dom_up;
            step_q <= step_dly_i;
            if (dom_up[N_DOM-1]) state_q <= ISO_REL;
          end else if (state_q == ISO_REL) begin
            iso_q   <= 1'b0;
            ready_q <= 1'b1;
            state_q <= UP;
          end
        RAMP_DN:
          if (dom_q == '0) state_q <= IDLE;
          else if (step_done) begin
            dom_q  <= dom_dn;
            step_q <= step_dly_i;
            if (dom_dn == '0) state_q <= IDLE;
          end else step_q <= step_q - 1'b1;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_io_supply_seq.sv
// tb_io_supply_seq: directed timing checks plus random stimulus against a step-level reference model
module tb_io_supply_seq;
  localparam int S = 2, DEB = 16, SW = 8, N = 4;
  localparam int M_IDLE = 0, M_DEB = 1, M_RISE = 2, M_ON = 3, M_FALL = 4;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vsup_ok_i = 1'b0;
  logic          enable_i = 1'b0;
  logic [SW-1:0] step_dly_i = '0;
  logic          fault_clr_i = 1'b0;
  logic [N-1:0]  dom_en_o;
  logic          iso_o, ready_o, fault_o;
  int vectors = 0, miscompares = 0, cyc = 0, base = 0;
  bit chk_on = 1'b0;
  int m_mode = M_IDLE, lvl = 0, runs = 0, el = 0, len = 1;
  bit m_fault = 1'b0;
  bit hist [S];

  io_supply_seq #(.SYNC_STAGES(S), .DEB_CYCLES(DEB), .STEP_W(SW), .N_DOM(N)) dut (
    .clk(clk), .rst_n(rst_n), .vsup_ok_i(vsup_ok_i), .enable_i(enable_i),
    .step_dly_i(step_dly_i), .fault_clr_i(fault_clr_i), .dom_en_o(dom_en_o),
    .iso_o(iso_o), .ready_o(ready_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: lvl counts completed steps; domains on = min(lvl, N), lvl = N+1 means fully up.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; lvl = 0; runs = 0; el = 0; len = 1; m_fault = 1'b0;
      for (int i = 0; i < S; i++) hist[i] = 1'b0;
    end else begin
      bit vs, f, bo;
      vs = hist[S-1];
      f  = m_fault && !fault_clr_i;
      bo = !vs && m_mode >= M_RISE;
      if (bo) begin
        m_mode = M_IDLE; lvl = 0; f = 1'b1;
      end else if (m_mode == M_IDLE) begin
        if (enable_i && vs && !m_fault) begin m_mode = M_DEB; runs = 0; end
      end else if (m_mode == M_DEB) begin
        if (!vs || !enable_i) m_mode = M_IDLE;
        else if (runs == DEB) begin m_mode = M_RISE; lvl = 1; el = 0; len = int'(step_dly_i) + 1; end
        else runs++;
      end else if (m_mode != M_FALL && !enable_i) begin
        m_mode = M_FALL; lvl = (lvl > N) ? N : lvl; el = 0; len = int'(step_dly_i) + 1;
      end else if (m_mode == M_RISE) begin
        el++;
        if (el == len) begin
          lvl++; el = 0; len = int'(step_dly_i) + 1;
          if (lvl == N + 1) m_mode = M_ON;
        end
      end else if (m_mode == M_FALL) begin
        el++;
        if (el == len) begin
          lvl--; el = 0; len = int'(step_dly_i) + 1;
          if (lvl == 0) m_mode = M_IDLE;
        end
      end
      m_fault = f;
      for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = vsup_ok_i;
    end
  end

  function automatic logic [N-1:0] exp_dom();
    int k;
    k = (lvl > N) ? N : lvl;
    return N'((1 << k) - 1);
  endfunction

  always @(negedge clk) if (chk_on) begin
    logic [N-1:0] ed;
    logic ei, er;
    ed = exp_dom();
    ei = (m_mode != M_ON);
    er = (m_mode == M_ON);
    vectors++;
    if (dom_en_o !== ed || iso_o !== ei || ready_o !== er || fault_o !== m_fault) begin
      miscompares++;
      $display("FAIL model t=%0t: dom=%b iso=%b rdy=%b flt=%b expected dom=%b iso=%b rdy=%b flt=%b",
               $time, dom_en_o, iso_o, ready_o, fault_o, ed, ei, er, m_fault);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic at_edge(input int e);
    while (cyc < base + e + 1) begin @(posedge clk); #1; end
  endtask

  task automatic mark();
    base = cyc;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!ready_o && n < budget) begin @(posedge clk); #1; n++; end
    vectors++;
    if (!ready_o) begin
      miscompares++;
      $display("FAIL wait_ready: ready_o=%b after %0d cycles", ready_o, n);
    end
  endtask

  initial begin
    int vh, eh;
    repeat (3) @(posedge clk);
    #1 chk_on = 1'b1;
    chk("reset_dom", 32'(dom_en_o), 0);
    chk("reset_iso", 32'(iso_o), 1);
    chk("reset_flt", 32'(fault_o), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // nominal ramp-up, step_dly=3
    enable_i = 1'b1; step_dly_i = 8'd3; vsup_ok_i = 1'b1; mark();
    at_edge(18); chk("up_e18", 32'(dom_en_o), 32'h0);
    at_edge(19); chk("up_e19", 32'(dom_en_o), 32'h1);
    at_edge(22); chk("up_e22", 32'(dom_en_o), 32'h1);
    at_edge(23); chk("up_e23", 32'(dom_en_o), 32'h3);
    at_edge(27); chk("up_e27", 32'(dom_en_o), 32'h7);
    at_edge(31); chk("up_e31", 32'(dom_en_o), 32'hf); chk("iso_e31", 32'(iso_o), 1);
    at_edge(34); chk("iso_e34", 32'(iso_o), 1);
    at_edge(35); chk("iso_e35", 32'(iso_o), 0); chk("rdy_e35", 32'(ready_o), 1);
    // graceful ramp-down from UP
    enable_i = 1'b0; mark();
    at_edge(0); chk("dn_rdy", 32'(ready_o), 0); chk("dn_iso", 32'(iso_o), 1); chk("dn_e0", 32'(dom_en_o), 32'hf);
    at_edge(3); chk("dn_e3", 32'(dom_en_o), 32'hf);
    at_edge(4); chk("dn_e4", 32'(dom_en_o), 32'h7);
    at_edge(8); chk("dn_e8", 32'(dom_en_o), 32'h3);
    at_edge(12); chk("dn_e12", 32'(dom_en_o), 32'h1);
    at_edge(16); chk("dn_e16", 32'(dom_en_o), 32'h0); chk("dn_flt", 32'(fault_o), 0);
    // debounce glitch at count 10
    enable_i = 1'b1; mark();
    at_edge(10); vsup_ok_i = 1'b0;
    at_edge(13); vsup_ok_i = 1'b1;
    at_edge(20); chk("gl_e20", 32'(dom_en_o), 32'h0);
    at_edge(32); chk("gl_e32", 32'(dom_en_o), 32'h0);
    at_edge(33); chk("gl_e33", 32'(dom_en_o), 32'h1);
    wait_ready(200);
    // brownout in UP
    vsup_ok_i = 1'b0; mark();
    at_edge(1); chk("bo_e1_rdy", 32'(ready_o), 1); chk("bo_e1_flt", 32'(fault_o), 0);
    at_edge(2); chk("bo_e2_dom", 32'(dom_en_o), 0); chk("bo_e2_flt", 32'(fault_o), 1);
    chk("bo_e2_iso", 32'(iso_o), 1); chk("bo_e2_rdy", 32'(ready_o), 0);
    vsup_ok_i = 1'b1;
    at_edge(60); chk("bo_hold_dom", 32'(dom_en_o), 0); chk("bo_hold_flt", 32'(fault_o), 1);
    fault_clr_i = 1'b1;
    at_edge(61); fault_clr_i = 1'b0; chk("bo_clr", 32'(fault_o), 0);
    wait_ready(200);
    // clear coincident with a new brownout
    vsup_ok_i = 1'b0; mark();
    at_edge(1); fault_clr_i = 1'b1;
    at_edge(2); fault_clr_i = 1'b0; chk("co_e2_flt", 32'(fault_o), 1); chk("co_e2_dom", 32'(dom_en_o), 0);
    at_edge(3); chk("co_e3_flt", 32'(fault_o), 1);
    // step_dly=0 ramp
    vsup_ok_i = 1'b1; step_dly_i = 8'd0; fault_clr_i = 1'b1; mark();
    at_edge(0); fault_clr_i = 1'b0;
    at_edge(18); chk("z_e18", 32'(dom_en_o), 32'h0);
    at_edge(19); chk("z_e19", 32'(dom_en_o), 32'h1);
    at_edge(20); chk("z_e20", 32'(dom_en_o), 32'h3);
    at_edge(21); chk("z_e21", 32'(dom_en_o), 32'h7);
    at_edge(22); chk("z_e22", 32'(dom_en_o), 32'hf); chk("z_iso22", 32'(iso_o), 1);
    at_edge(23); chk("z_iso23", 32'(iso_o), 0);
    // step length captured at step start
    enable_i = 1'b0; mark();
    at_edge(0); step_dly_i = 8'd7;
    at_edge(1); chk("cap_e1", 32'(dom_en_o), 32'h7);
    step_dly_i = 8'd0;
    at_edge(8); chk("cap_e8", 32'(dom_en_o), 32'h7);
    at_edge(9); chk("cap_e9", 32'(dom_en_o), 32'h3);
    at_edge(10); chk("cap_e10", 32'(dom_en_o), 32'h1);
    at_edge(11); chk("cap_e11", 32'(dom_en_o), 32'h0);
    // async reset mid ramp-up
    enable_i = 1'b1; step_dly_i = 8'd3; mark();
    at_edge(22);
    #2 rst_n = 1'b0;
    #1 chk("ar_dom", 32'(dom_en_o), 0); chk("ar_iso", 32'(iso_o), 1); chk("ar_rdy", 32'(ready_o), 0);
    @(posedge clk); #1 rst_n = 1'b1; mark();
    at_edge(18); chk("ar_e18", 32'(dom_en_o), 32'h0);
    at_edge(19); chk("ar_e19", 32'(dom_en_o), 32'h1);
    wait_ready(200);
    // random phase
    vh = 0; eh = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      if (--vh <= 0) begin vsup_ok_i = ($urandom_range(0, 7) != 0); vh = $urandom_range(1, 90); end
      if (--eh <= 0) begin enable_i = ($urandom_range(0, 3) != 0); eh = $urandom_range(1, 70); end
      fault_clr_i = ($urandom_range(0, 24) == 0);
      step_dly_i  = SW'($urandom_range(0, 4));
    end
    @(posedge clk); #1 chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
